// File: rtl/output_io_pkg.sv
// output_io_pkg: mode names, parameter limits and width helper for the output IO bank
package output_io_pkg;
  localparam string OUT_BUFF_MODE = "out_buff";
  localparam string OUT_REG_MODE = "out_reg";
  localparam int MAX_DEPTH = 4;
  localparam int MAX_WIDTH = 32;
  function automatic int clog2(input int v);
    for (int r = 0; r < 32; r++) if ((64'd1 << r) >= 64'(v)) return r;
    return 32;
  endfunction
endpackage

// File: rtl/output_io_bank_stage.sv
// out_pipe_stage: one data+OE pipeline stage with async reset, sync clear and enable
module out_pipe_stage #(
  parameter int W = 1,
  parameter logic [W-1:0] RV = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= RV;
    else if (clr) q <= RV;
    else if (en) q <= d;
endmodule

// File: rtl/output_io_bank.sv
// output_io_bank: WIDTH-channel fabric-to-pad output bank, buffered or DEPTH-stage registered
(* whitebox *)
(* MODES = "out_buff;out_reg" *)
(* FASM_PARAMS = "MODE=OUT_REG" *)
module output_io_bank
  import output_io_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter string MODE = "out_reg",
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] INIT = '0,
  parameter logic OE_INIT = 1'b0
) (
  input  logic             IQC,
  input  logic             QRT,
  input  logic             OCE,
  input  logic             SRST,
  input  logic [WIDTH-1:0] OQI,
  input  logic             OE,
  output logic [WIDTH-1:0] F2A,
  output logic             F2A_OE,
  output logic             VLD
);
  if (!(MODE == OUT_BUFF_MODE || MODE == OUT_REG_MODE) || WIDTH < 1 || WIDTH > MAX_WIDTH ||
      DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad
    $error("output_io_bank: illegal WIDTH, DEPTH or MODE");
  end
  if (MODE == OUT_BUFF_MODE) begin : g_buff
    assign F2A = OQI;
    assign F2A_OE = OE;
    assign VLD = 1'b1;
  end else begin : g_reg
    localparam int CW = clog2(DEPTH + 1);
    logic [WIDTH:0] st [DEPTH+1];
    logic [CW-1:0] cnt;
    // st[0] is the fabric input; st[DEPTH] is the pad-facing stage
    assign st[0] = {OQI, OE};
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      out_pipe_stage #(.W(WIDTH + 1), .RV({INIT, OE_INIT})) u_stage (
        .clk(IQC), .rst_n(QRT), .clr(SRST), .en(OCE), .d(st[i]), .q(st[i+1])
      );
    end
    // fill counter saturates so VLD stays high until the next clear
    always_ff @(posedge IQC or negedge QRT)
      if (!QRT) cnt <= '0;
      else if (SRST) cnt <= '0;
      else if (OCE && cnt != CW'(DEPTH)) cnt <= cnt + CW'(1);
    assign F2A = st[DEPTH][WIDTH:1];
    assign F2A_OE = st[DEPTH][0];
    assign VLD = cnt == CW'(DEPTH);
  end
endmodule

// File: tb/tb_output_io_bank.sv
// tb_output_io_bank: scoreboard bench over six registered configurations and one buffer instance
module tb_output_io_bank;
  typedef struct {
    int id;
    logic [31:0] f;
    logic e;
    logic v;
  } exp_t;
  localparam int NR = 6;
  localparam int WS[NR] = '{8, 8, 1, 1, 32, 32};
  localparam int DS[NR] = '{2, 3, 1, 4, 1, 4};
  localparam logic [31:0] INITS[NR] = '{32'hA5, 32'h0, 32'h1, 32'h0, 32'hDEADBEEF, 32'h01234567};
  localparam logic OEI[NR] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic iqc = 0, run = 1, qrt = 1, oce = 0, srst = 0, oe = 0;
  logic [31:0] oqi = 0;
  logic [31:0] f2a [7];
  logic f2a_oe [7];
  logic vld [7];
  logic [3:0] fb;
  exp_t sb[$];
  logic [32:0] hist[$];
  int compared = 0, mismatched = 0, pushed = 0;
  event async_ev;

  for (genvar g = 0; g < NR; g++) begin : g_dut
    localparam int W = WS[g];
    logic [W-1:0] f;
    output_io_bank #(.WIDTH(W), .MODE("out_reg"), .DEPTH(DS[g]), .INIT(INITS[g][W-1:0]),
                     .OE_INIT(OEI[g])) u_dut (
      .IQC(iqc), .QRT(qrt), .OCE(oce), .SRST(srst), .OQI(oqi[W-1:0]), .OE(oe),
      .F2A(f), .F2A_OE(f2a_oe[g]), .VLD(vld[g])
    );
    assign f2a[g] = 32'(f);
  end
  output_io_bank #(.WIDTH(4), .MODE("out_buff")) u_buff (
    .IQC(iqc), .QRT(qrt), .OCE(oce), .SRST(srst), .OQI(oqi[3:0]), .OE(oe),
    .F2A(fb), .F2A_OE(f2a_oe[6]), .VLD(vld[6])
  );
  assign f2a[6] = 32'(fb);

  always begin
    #5;
    if (run) iqc = ~iqc;
  end

  // reference: output is the sample accepted DEPTH advances ago, INIT until that many exist
  task automatic push_all();
    exp_t x;
    int n;
    logic [31:0] m;
    for (int g = 0; g < 7; g++) begin
      x.id = g;
      n = hist.size();
      if (g == 6) begin
        x.f = {28'h0, oqi[3:0]};
        x.e = oe;
        x.v = 1'b1;
      end else begin
        m = (WS[g] == 32) ? 32'hFFFF_FFFF : (32'h1 << WS[g]) - 32'h1;
        x.v = n >= DS[g];
        x.f = x.v ? hist[n-DS[g]][32:1] & m : INITS[g];
        x.e = x.v ? hist[n-DS[g]][0] : OEI[g];
      end
      sb.push_back(x);
      pushed++;
    end
  endtask

  task automatic cyc(input logic [31:0] d, input logic e, input logic c, input logic s);
    oqi = d;
    oe = e;
    oce = c;
    srst = s;
    @(posedge iqc);
    if (!qrt || srst) hist.delete();
    else if (oce) begin
      hist.push_back({oqi, oe});
      if (hist.size() > 4) void'(hist.pop_front());
    end
    push_all();
    @(negedge iqc);
    #1;
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge iqc or async_ev);
      while (sb.size() > 0) begin
        x = sb.pop_front();
        compared += 3;
        if (f2a[x.id] !== x.f) begin
          mismatched++;
          $display("FAIL f2a inst%0d t=%0t got %h want %h", x.id, $time, f2a[x.id], x.f);
        end
        if (f2a_oe[x.id] !== x.e) begin
          mismatched++;
          $display("FAIL f2a_oe inst%0d t=%0t got %b want %b", x.id, $time, f2a_oe[x.id], x.e);
        end
        if (vld[x.id] !== x.v) begin
          mismatched++;
          $display("FAIL vld inst%0d t=%0t got %b want %b", x.id, $time, vld[x.id], x.v);
        end
      end
    end
  end

  initial begin
    #1 qrt = 0;
    #1 push_all();
    ->async_ev;
    @(negedge iqc);
    #1 qrt = 1;
    cyc(32'h01, 1, 1, 0);
    cyc(32'h02, 0, 1, 0);
    cyc(32'h03, 1, 1, 0);
    cyc(32'h04, 1, 1, 0);
    cyc(32'h00, 0, 1, 1);
    cyc(32'h11, 1, 1, 0);
    repeat (3) cyc(32'h11, 1, 0, 0);
    cyc(32'h22, 0, 1, 0);
    cyc(32'h33, 1, 0, 0);
    cyc(32'h44, 1, 1, 0);
    cyc(32'h55, 0, 1, 0);
    cyc(32'h66, 1, 1, 0);
    cyc(32'hFF, 1, 1, 1);
    repeat (5) cyc($urandom, 1'($urandom_range(0, 1)), 1, 0);
    cyc(32'h3C, 1, 1, 0);
    // clock stopped: reset and buffer path must respond with no edge
    run = 0;
    qrt = 0;
    hist.delete();
    oqi = 32'h5;
    oe = 1;
    #1 push_all();
    ->async_ev;
    #1 oqi = 32'hA;
    oe = 0;
    #1 push_all();
    ->async_ev;
    #1 qrt = 1;
    run = 1;
    repeat (600) begin
      qrt = $urandom_range(0, 29) != 0;
      cyc($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    qrt = 1;
    repeat (6) cyc($urandom, 1'($urandom_range(0, 1)), 1, 0);
    @(negedge iqc);
    #1 compared++;
    if (sb.size() != 0 || compared != pushed * 3 + 1) begin
      mismatched++;
      $display("FAIL drain pending %0d checked %0d want %0d", sb.size(), compared - 1, pushed * 3);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/output_io_bank.md
Name: output_io_bank

Overview:
- Parametrised successor of the single-bit output IO cell. Drives WIDTH fabric-to-pad output channels (F2A) plus a shared output-enable.
- Modes: pure buffer, or a registered pipeline of DEPTH stages.
- Registered mode adds clock enable, synchronous clear to INIT, an output-enable pipeline aligned with data, and a pipeline-primed flag.
- Instantiated per IO bank in the AP3 primitive library; replaces per-bit OUTPUT_IO where bussed registered outputs are needed.

Parameters:
- WIDTH, 1, number of output channels (1..32).
- MODE, "out_reg", "out_buff" (combinational pass-through) or "out_reg" (registered pipeline).
- DEPTH, 1, pipeline stages in out_reg mode (1..4); ignored in out_buff.
- INIT, {WIDTH{1'b0}}, value loaded into every data stage on reset and SRST.
- OE_INIT, 1'b0, value loaded into every OE stage on reset and SRST.

Ports:
- IQC  input  1  clock. Rising edge active.
- QRT  input  1  reset, asynchronous, active-low.
- OCE  input  1  clock enable; pipeline advances only when 1.
- SRST  input  1  synchronous clear, active-high.
- OQI  input  WIDTH  output data from fabric.
- OE  input  1  output-enable request from fabric.
- F2A  output  WIDTH  data to pad.
- F2A_OE  output  1  output enable to pad, aligned with F2A.
- VLD  output  1  pipeline primed. All stages hold post-reset data.

Behaviour:
- Interface fixed: one clock IQC; QRT is asynchronous, active-low.

out_buff mode:
- F2A=OQI, F2A_OE=OE, VLD=1, all combinational.
- IQC, QRT, OCE and SRST are ignored. No flops are inferred.

out_reg mode, pipeline:
- Data stages d[0..DEPTH-1], OE stages e[0..DEPTH-1], fill counter cnt (width clog2(DEPTH+1)).
- Outputs: F2A=d[DEPTH-1], F2A_OE=e[DEPTH-1], VLD=(cnt==DEPTH). All registered, no combinational path from inputs.

out_reg mode, reset (QRT=0):
- Immediately, without a clock edge: d[*]=INIT, e[*]=OE_INIT, cnt=0, VLD=0.
- State is held while QRT=0. This also applies mid-operation: in-flight data is discarded.

out_reg mode, clock-edge priority (highest first):
- SRST=1: d[*]=INIT, e[*]=OE_INIT, cnt=0. Acts regardless of OCE.
- OCE=1: d[0]<=OQI, e[0]<=OE, d[i]<=d[i-1], e[i]<=e[i-1]; cnt<=cnt+1, saturating at DEPTH.
- Otherwise: all state holds.

out_reg mode, timing and boundaries:
- Latency from OQI/OE to F2A/F2A_OE is exactly DEPTH OCE-qualified edges. With OCE tied 1 this is DEPTH cycles.
- VLD rises on the edge that performs the DEPTH-th advance after reset or SRST. It stays 1 until the next reset or SRST.
- cnt never wraps.
- OCE=0 freezes outputs and VLD.
- SRST and OCE both 1: SRST wins, and the OQI sample is dropped.
- QRT release: the first edge with QRT=1 may advance. The implementation must not require a synchronised release internally; release sync is the bank-level responsibility.
- Illegal parameters (DEPTH outside 1..4, WIDTH outside 1..32, unknown MODE) are rejected at elaboration.

Decomposition:
- Shared package output_io_pkg holds:
  - MODE string constants (OUT_BUFF_MODE, OUT_REG_MODE);
  - MAX_DEPTH=4 and MAX_WIDTH=32;
  - the clog2 helper for cnt width.
- Sub-module out_pipe_stage:
  - one stage of WIDTH+1 bits with async active-low reset to {INIT,OE_INIT}, sync clear, and enable;
  - generated DEPTH times.
- Fill counter and mode mux live in the top module.
- Carry the same MODES/FASM_PARAMS/whitebox attributes as the existing IO primitives.

Test Plan:
- Reset values: MODE=out_reg, WIDTH=8, DEPTH=2, INIT=8'hA5. Assert QRT=0 mid-stream with F2A=8'h3C → F2A=8'hA5, F2A_OE=0 and VLD=0 immediately, with no IQC edge.
- Latency and VLD: DEPTH=3, OCE=1, OQI=8'h01,02,03,04 on consecutive edges after reset → F2A=8'h01 after edge 3. VLD goes 0→1 on edge 3. F2A_OE follows OE with the same 3-edge delay.
- Clock-enable stall: DEPTH=2, drive 8'h11, OCE=0 for 3 edges, then 8'h22 with OCE=1 → F2A holds between advances. 8'h11 appears after the 2nd OCE edge. VLD asserts only after 2 OCE=1 edges.
- SRST priority: SRST=1 and OCE=1 with OQI=8'hFF while primed → F2A=INIT next edge, VLD=0. Refill takes DEPTH OCE edges.
- Buffer mode: MODE=out_buff, WIDTH=4. Toggle OQI 4'h5→4'hA with no clock and QRT=0 → F2A tracks combinationally; F2A_OE=OE; VLD=1.
- Width/depth sweep: WIDTH ∈ {1,32} × DEPTH ∈ {1,4} with random OQI/OE/OCE/SRST against a reference model → bit-exact F2A, F2A_OE and VLD every cycle.
